// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file write arbiter: arbitration FSM
// encoding and the conflict-counter width.
package regfile_arb_pkg;

  // Arbitration state: the named requester wins when both are valid.
  typedef enum logic [0:0] {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } arb_state_e;

  localparam int unsigned CONFLICT_CNT_WIDTH = 16;

endpackage

// File: rtl/regfile_write_arbiter_decoder.sv
// Binary-to-one-hot register address decoder.
module regfile_write_arbiter_decoder #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0]      input_address,
  output logic [(1<<ADDR_WIDTH)-1:0] decoded_output
);

  // One-hot decode of the address.
  always_comb begin
    decoded_output                = '0;
    decoded_output[input_address] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the ALU (0) and load (1) writeback ports onto a single
// register-file write port with one cycle of latency. Round-robin between
// the two requesters by default; defining WRITE_ARB_FIXED_PRIORITY_EN makes
// requester 0 always win conflicts.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          hold,
  input  logic                          req0_valid,
  input  logic [ADDR_WIDTH-1:0]         req0_addr,
  input  logic [DATA_WIDTH-1:0]         req0_data,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [ADDR_WIDTH-1:0]         req1_addr,
  input  logic [DATA_WIDTH-1:0]         req1_data,
  output logic                          req1_ready,
  output logic [(1<<ADDR_WIDTH)-1:0]    wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_strobe,
  output logic [CONFLICT_CNT_WIDTH-1:0] conflict_count
);

  localparam int unsigned NumRegs = 1 << ADDR_WIDTH;
  localparam logic [CONFLICT_CNT_WIDTH-1:0] CntOne = {{(CONFLICT_CNT_WIDTH-1){1'b0}}, 1'b1};

  arb_state_e                    state_q, state_d;
  logic [NumRegs-1:0]            wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]         wr_data_q, wr_data_d;
  logic                          wr_strobe_q, wr_strobe_d;
  logic [CONFLICT_CNT_WIDTH-1:0] conflict_q, conflict_d;

  logic                  arb_en;
  logic                  grant0, grant1, xfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [NumRegs-1:0]    dec_out;

  regfile_write_arbiter_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_decoder (
    .input_address  (sel_addr),
    .decoded_output (dec_out)
  );

  // Grant selection: a lone requester always wins; conflicts follow the FSM.
  always_comb begin
    arb_en = reset && !hold;
`ifdef WRITE_ARB_FIXED_PRIORITY_EN
    grant0 = arb_en && req0_valid;
    grant1 = arb_en && req1_valid && !req0_valid;
`else
    grant0 = arb_en && req0_valid && (!req1_valid || (state_q == PRI0));
    grant1 = arb_en && req1_valid && (!req0_valid || (state_q == PRI1));
`endif
    xfer     = grant0 || grant1;
    sel_addr = grant1 ? req1_addr : req0_addr;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Next-state: priority flips to the loser, write port captures the winner.
  always_comb begin
`ifdef WRITE_ARB_FIXED_PRIORITY_EN
    state_d = PRI0;
`else
    state_d = state_q;
    if (grant0) begin
      state_d = PRI1;
    end else if (grant1) begin
      state_d = PRI0;
    end
`endif
    wr_strobe_d = xfer;
    wr_data_d   = wr_data_q;
    if (xfer) begin
      wr_data_d = grant1 ? req1_data : req0_data;
    end
    // Writes to $zero still strobe but never enable a register.
    wr_en_d = (xfer && (sel_addr != '0)) ? dec_out : '0;
    conflict_d = conflict_q;
    if (req0_valid && req1_valid && !hold && (conflict_q != '1)) begin
      conflict_d = conflict_q + CntOne;
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= PRI0;
      wr_en_q     <= '0;
      wr_data_q   <= '0;
      wr_strobe_q <= 1'b0;
      conflict_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      wr_strobe_q <= wr_strobe_d;
      conflict_q  <= conflict_d;
    end
  end

  assign wr_en          = wr_en_q;
  assign wr_data        = wr_data_q;
  assign wr_strobe      = wr_strobe_q;
  assign conflict_count = conflict_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        hold;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [31:0] wr_en;
  logic [31:0] wr_data;
  logic        wr_strobe;
  logic [15:0] conflict_count;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_write_arbiter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .hold           (hold),
    .req0_valid     (req0_valid),
    .req0_addr      (req0_addr),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_addr      (req1_addr),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_strobe      (wr_strobe),
    .conflict_count (conflict_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic exp_g0;
    reset = 1'b0; hold = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h0;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'h0;
    #1;
    check("ready0_in_reset", req0_ready, 1'b0);
    step();
    step();
    check("rst_wr_en", wr_en, 32'h0);
    check("rst_strobe", wr_strobe, 1'b0);
    check("rst_wr_data", wr_data, 32'h0);
    check("rst_conflict", conflict_count, 16'h0);
    reset = 1'b1; req0_valid = 1'b0;

    // Single request from requester 0.
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    check("single_ready0", req0_ready, 1'b1);
    check("single_ready1", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    check("single_strobe", wr_strobe, 1'b1);
    check("single_wr_en", wr_en, 32'h0000_0020);
    check("single_wr_data", wr_data, 32'hDEADBEEF);
    step();
    check("idle_strobe", wr_strobe, 1'b0);
    check("idle_wr_en", wr_en, 32'h0);
    check("idle_data_hold", wr_data, 32'hDEADBEEF);

    // Re-reset so the next conflict starts in PRI0.
    reset = 1'b0;
    step();
    reset = 1'b1;

    // Conflict after reset: req0 first, then req1.
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hAAAA0003;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'hBBBB0004;
    #1;
    check("conf_ready0", req0_ready, 1'b1);
    check("conf_ready1", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    check("conf_en_first", wr_en, 32'h8);
    check("conf_data_first", wr_data, 32'hAAAA0003);
    check("conf_ready1_after", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    check("conf_en_second", wr_en, 32'h10);
    check("conf_data_second", wr_data, 32'hBBBB0004);
    check("conf_count_1", conflict_count, 16'd1);

    // Sustained conflict, same address: grant order decides final data.
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h11111111;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h22222222;
    for (int i = 0; i < 4; i++) begin
`ifdef WRITE_ARB_FIXED_PRIORITY_EN
      exp_g0 = 1'b1;
`else
      exp_g0 = (i % 2 == 0);
`endif
      #1;
      check($sformatf("rr_ready0_%0d", i), req0_ready, exp_g0);
      check($sformatf("rr_ready1_%0d", i), req1_ready, !exp_g0);
      step();
      check($sformatf("rr_data_%0d", i), wr_data, exp_g0 ? 32'h11111111 : 32'h22222222);
      check($sformatf("rr_en_%0d", i), wr_en, 32'h80);
    end
    check("rr_conflict_5", conflict_count, 16'd5);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    check("rr_idle_strobe", wr_strobe, 1'b0);

    // Write to $zero from requester 1.
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
    #1;
    check("zero_ready1", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    check("zero_strobe", wr_strobe, 1'b1);
    check("zero_wr_en", wr_en, 32'h0);
    check("zero_wr_data", wr_data, 32'h1234);

    // Stall: nothing granted, conflicts under hold not counted.
    hold = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'hCAFEF00D;
    req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'h0BADBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("hold_ready0_%0d", i), req0_ready, 1'b0);
      check($sformatf("hold_ready1_%0d", i), req1_ready, 1'b0);
      step();
      check($sformatf("hold_strobe_%0d", i), wr_strobe, 1'b0);
    end
    check("hold_conflict", conflict_count, 16'd5);
    hold = 1'b0; req1_valid = 1'b0;
    step();
    check("pend_strobe", wr_strobe, 1'b1);
    check("pend_wr_en", wr_en, 32'h200);
    // Reset while that write is registered.
    reset = 1'b0;
    #1;
    check("rst_mid_ready0", req0_ready, 1'b0);
    step();
    reset = 1'b1;
    check("rst_mid_strobe", wr_strobe, 1'b0);
    check("rst_mid_wr_en", wr_en, 32'h0);
    check("rst_mid_conflict", conflict_count, 16'h0);
    // First cycle out of reset arbitrates with PRI0 priority.
    req1_valid = 1'b1;
    #1;
    check("post_rst_ready0", req0_ready, 1'b1);
    check("post_rst_ready1", req1_ready, 1'b0);

    // Saturation of the conflict counter.
    for (int i = 0; i < 65540; i++) begin
      step();
    end
    check("sat_count", conflict_count, 16'hFFFF);
    step();
    check("sat_hold", conflict_count, 16'hFFFF);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
